perip_riego_multicanal: RTL and testbench
=========================================

Name: perip_riego_multicanal

Overview:
Parametrised multi-channel successor to the single-valve irrigation peripheral. It is memory-mapped on the CPU bus with the same cs/rd/wr/addr/d_in/d_out protocol. Per-channel turbidity samples and irrigation requests are written by firmware. A round-robin scheduler grants one valve at a time, after a handshake with the ESP module (enable_esp/ready_from_esp) and for a programmable duration, with ready timeout and sticky fault reporting.

Parameters:
N_CH, 4, number of valve channels (1..8)
TURB_W, 4, turbidity sample width in bits (1..8)
TIMER_W, 16, width of the duration and timeout counters
DEF_THRESH, 4'd8, reset value of the turbidity threshold
DEF_TIMEOUT, 1000, reset value of the ESP-ready timeout in cycles

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
d_in  input  32  bus write data
cs  input  1  peripheral select
addr  input  32  bus address; only addr[4:0] is decoded
rd  input  1  read strobe
wr  input  1  write strobe
ready_from_esp  input  1  ESP acknowledges that the pump/line is ready
d_out  output  32  read data, combinational; 0 when !(cs&&rd) or the address is unmapped
enable_esp  output  1  request to the ESP, registered
led_valvula  output  N_CH  one-hot valve drive, registered

Behaviour:
- Register map (addr[4:0]); a write commits on the clk edge when cs&&wr:
  - 0x00 CTRL (RW): bit0 run.
  - 0x01 SET_TURBIDEZ (W): d_in[15:8] = channel, d_in[TURB_W-1:0] = sample. Writes with channel >= N_CH are ignored.
  - 0x02 THRESH (RW): [TURB_W-1:0].
  - 0x03 GET_ENABLE (R): {31'b0, enable_esp}.
  - 0x04 GET_LED (R): led_valvula, zero-extended.
  - 0x05 DURATION (RW): [TIMER_W-1:0].
  - 0x06 TIMEOUT (RW): [TIMER_W-1:0].
  - 0x07 REQ (W: OR d_in[N_CH-1:0] into pending; R: pending).
  - 0x08 STATUS (R): [2:0] state, [10:8] active channel, [23:16] fault mask, [31:24] blocked mask.
  - 0x09 FAULT_CLR (W1C on the fault mask).
- Reset values: turbidity regs 0, THRESH=DEF_THRESH, DURATION=0, TIMEOUT=DEF_TIMEOUT, run=0, pending=0, fault=0, blocked=0, state IDLE, active channel 0, rr pointer 0, enable_esp=0, led_valvula=0.
- A channel is eligible when pending[i] && !fault[i] && turb[i] <= THRESH.
  - blocked[i] = pending[i] && turb[i] > THRESH, updated every cycle.
- FSM states (encoding for STATUS): IDLE=0, SCAN=1, REQ=2, OPEN=3, DONE=4.
  - IDLE: when run=1 -> SCAN.
  - SCAN:
    - Pick the first eligible channel starting at the rr pointer, wrapping modulo N_CH, within a single cycle.
    - If one is found, latch it as the active channel, load the timeout counter, assert enable_esp -> REQ.
    - If none is found, stay in SCAN.
    - If run=0 -> IDLE.
  - REQ:
    - enable_esp=1.
    - ready_from_esp=1 -> load the duration counter, set led_valvula[ch]=1 on the next edge -> OPEN.
    - Timeout counter reaches 0 first -> set fault[ch], clear pending[ch], enable_esp=0 -> DONE.
  - OPEN:
    - The counter decrements each cycle; the valve is on for exactly max(DURATION,1) cycles.
    - At 0: valve off, enable_esp=0, clear pending[ch] -> DONE.
    - ready_from_esp falling during OPEN is ignored.
  - DONE: rr pointer = ch+1 modulo N_CH -> SCAN on the next cycle (IDLE if run=0).
- run cleared mid-operation: the current REQ/OPEN completes normally, then the FSM goes to IDLE. Firmware stops a channel immediately only by writing the REQ register in a later revision; it is not supported here.
- A REQ write in the same cycle as the FSM clearing the same pending bit: the write wins (bit stays 1), so the channel is re-served later.
- A TURBIDEZ write raising turb above THRESH during OPEN does not close the valve; it only affects the next eligibility check.
- A FAULT_CLR write in the same cycle the FSM sets the same fault bit: the set wins.
- Asynchronous reset assertion in any state: outputs go to their reset values immediately, without waiting for clk.
- At most one led_valvula bit is ever high; enable_esp=1 whenever any led_valvula bit is high.

Test Plan:
- THRESH=8, turb[2]=5, DURATION=3, REQ=0x04, run=1, ready_from_esp tied 1 -> enable_esp rises; led_valvula=0x4 for exactly 3 cycles; REQ readback 0x0; STATUS state returns to 1.
- REQ=0xF with all turb=0 and rr pointer 0 -> channels served in order 0,1,2,3; after channel 3, a new REQ=0x1 is served next (wrap).
- turb[1]=12, THRESH=8, REQ=0x2 -> no valve; STATUS blocked=0x02. Write turb[1]=3 -> channel 1 served; blocked returns to 0.
- TIMEOUT=10, REQ=0x1, ready_from_esp held 0 -> enable_esp high for 10 cycles then low; fault=0x01; channel 0 no longer eligible until FAULT_CLR=0x1.
- Async reset pulsed low mid-OPEN, between clk edges -> led_valvula=0 and enable_esp=0 at once; all registers read their reset values.
- Reads of unmapped address 0x1F, and any read with cs=0 -> d_out=0. A SET_TURBIDEZ write to channel 7 when N_CH=4 -> no register changes.

Source files
------------

// File: rtl/perip_riego_multicanal.sv
// perip_riego_multicanal: memory-mapped multi-channel irrigation scheduler.
// Grants one valve at a time in round-robin order after an ESP ready handshake.
module perip_riego_multicanal #(
  parameter int N_CH = 4,
  parameter int TURB_W = 4,
  parameter int TIMER_W = 16,
  parameter logic [TURB_W-1:0] DEF_THRESH = TURB_W'(8),
  parameter int DEF_TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     d_in,
  input  logic            cs,
  input  logic [31:0]     addr,
  input  logic            rd,
  input  logic            wr,
  input  logic            ready_from_esp,
  output logic [31:0]     d_out,
  output logic            enable_esp,
  output logic [N_CH-1:0] led_valvula
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_REQ  = 3'd2,
    S_OPEN = 3'd3,
    S_DONE = 3'd4
  } state_t;
  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_TURB = 5'h01;
  localparam logic [4:0] A_THRESH = 5'h02;
  localparam logic [4:0] A_EN = 5'h03;
  localparam logic [4:0] A_LED = 5'h04;
  localparam logic [4:0] A_DUR = 5'h05;
  localparam logic [4:0] A_TOUT = 5'h06;
  localparam logic [4:0] A_REQ = 5'h07;
  localparam logic [4:0] A_STAT = 5'h08;
  localparam logic [4:0] A_FCLR = 5'h09;
  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic [TURB_W-1:0]  turb_q [N_CH];
  logic [TURB_W-1:0]  turb_d [N_CH];
  logic [TURB_W-1:0]  thresh_q, thresh_d;
  logic [TIMER_W-1:0] dur_q, dur_d;
  logic [TIMER_W-1:0] tout_q, tout_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [N_CH-1:0]    fault_q, fault_d;
  logic [N_CH-1:0]    blocked_q, blocked_d;
  logic [N_CH-1:0]    led_q, led_d;
  logic [2:0]         ch_q, ch_d;
  logic [2:0]         rr_q, rr_d;
  logic               en_q, en_d;
  logic               we;
  logic [4:0]         a;
  logic [N_CH-1:0]    elig, rot, ch_oh, pend_clr, fault_set;
  logic               found;
  logic [2:0]         off, sel;
  logic [3:0]         sum;
  logic [31:0]        rdata;
  logic               unused_bits;
  assign unused_bits = ^{addr, d_in};
  assign we = cs && wr;
  assign a = addr[4:0];
  assign ch_oh = N_CH'(1) << ch_q;
  assign enable_esp = en_q;
  assign led_valvula = led_q;
  always_comb begin
    run_d = (we && a == A_CTRL) ? d_in[0] : run_q;
    thresh_d = (we && a == A_THRESH) ? d_in[TURB_W-1:0] : thresh_q;
    dur_d = (we && a == A_DUR) ? d_in[TIMER_W-1:0] : dur_q;
    tout_d = (we && a == A_TOUT) ? d_in[TIMER_W-1:0] : tout_q;
    for (int i = 0; i < N_CH; i++) begin
      turb_d[i] = (we && a == A_TURB && d_in[15:8] == 8'(i)) ? d_in[TURB_W-1:0] : turb_q[i];
      elig[i] = pend_q[i] && !fault_q[i] && turb_q[i] <= thresh_q;
      blocked_d[i] = pend_q[i] && turb_q[i] > thresh_q;
    end
    // Rotate eligibility so bit 0 is the rr pointer, then take the lowest set bit
    rot = N_CH'({elig, elig} >> rr_q);
    found = |rot;
    off = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (rot[k]) off = 3'(k);
    sum = {1'b0, rr_q} + {1'b0, off};
    sel = (sum >= 4'(N_CH)) ? 3'(sum - 4'(N_CH)) : sum[2:0];
  end
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    en_d = en_q;
    led_d = led_q;
    pend_clr = '0;
    fault_set = '0;
    case (state_q)
      S_IDLE: state_d = run_q ? S_SCAN : S_IDLE;
      S_SCAN: begin
        if (!run_q) state_d = S_IDLE;
        else if (found) begin
          ch_d = sel;
          cnt_d = tout_q;
          en_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ready_from_esp) begin
          cnt_d = dur_q;
          led_d = ch_oh;
          state_d = S_OPEN;
        end else if (cnt_q <= TIMER_W'(1)) begin
          fault_set = ch_oh;
          pend_clr = ch_oh;
          en_d = 1'b0;
          state_d = S_DONE;
        end else cnt_d = cnt_q - TIMER_W'(1);
      end
      // A zero duration still opens the valve for one cycle
      S_OPEN: begin
        if (cnt_q <= TIMER_W'(1)) begin
          led_d = '0;
          en_d = 1'b0;
          pend_clr = ch_oh;
          state_d = S_DONE;
        end else cnt_d = cnt_q - TIMER_W'(1);
      end
      S_DONE: begin
        rr_d = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;
        state_d = run_q ? S_SCAN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Firmware request write beats the FSM clear; fault set beats firmware clear
    pend_d = (pend_q & ~pend_clr) | ((we && a == A_REQ) ? d_in[N_CH-1:0] : '0);
    fault_d = (fault_q & ~((we && a == A_FCLR) ? d_in[N_CH-1:0] : '0)) | fault_set;
  end
  always_comb begin
    rdata = '0;
    case (a)
      A_CTRL: rdata = {31'd0, run_q};
      A_THRESH: rdata = 32'(thresh_q);
      A_EN: rdata = {31'd0, en_q};
      A_LED: rdata = 32'(led_q);
      A_DUR: rdata = 32'(dur_q);
      A_TOUT: rdata = 32'(tout_q);
      A_REQ: rdata = 32'(pend_q);
      A_STAT: rdata = {8'(blocked_q), 8'(fault_q), 5'd0, ch_q, 5'd0, state_q};
      default: rdata = '0;
    endcase
    d_out = (cs && rd) ? rdata : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      run_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) turb_q[i] <= '0;
      thresh_q <= DEF_THRESH;
      dur_q <= '0;
      tout_q <= TIMER_W'(DEF_TIMEOUT);
      cnt_q <= '0;
      pend_q <= '0;
      fault_q <= '0;
      blocked_q <= '0;
      led_q <= '0;
      ch_q <= '0;
      rr_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      for (int i = 0; i < N_CH; i++) turb_q[i] <= turb_d[i];
      thresh_q <= thresh_d;
      dur_q <= dur_d;
      tout_q <= tout_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      fault_q <= fault_d;
      blocked_q <= blocked_d;
      led_q <= led_d;
      ch_q <= ch_d;
      rr_q <= rr_d;
      en_q <= en_d;
    end
  end
endmodule

// File: tb/tb_perip_riego_multicanal.sv
// tb_perip_riego_multicanal: directed checks of the multi-channel irrigation peripheral.
module tb_perip_riego_multicanal;
  localparam logic [4:0] A_CTRL = 5'h00, A_TURB = 5'h01, A_THRESH = 5'h02, A_EN = 5'h03,
                         A_LED = 5'h04, A_DUR = 5'h05, A_TOUT = 5'h06, A_REQ = 5'h07,
                         A_STAT = 5'h08, A_FCLR = 5'h09;
  logic clk = 0, reset, cs, rd, wr, ready;
  logic [31:0] d_in, addr, d_out;
  logic enable_esp;
  logic [3:0] led;
  int n_tests = 0, n_fail = 0;
  logic [31:0] v;
  int len;
  perip_riego_multicanal dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .ready_from_esp(ready), .d_out(d_out), .enable_esp(enable_esp), .led_valvula(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1; wr = 1; addr = {27'd0, a}; d_in = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask
  task automatic rd_reg(input logic [4:0] a, output logic [31:0] q);
    @(negedge clk);
    cs = 1; rd = 1; addr = {27'd0, a};
    #1 q = d_out;
    cs = 0; rd = 0;
  endtask
  task automatic wait_led(input bit nz);
    int c = 0;
    while (((led != 0) != nz) && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic wait_en(input bit lv);
    int c = 0;
    while ((enable_esp != lv) && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 0; cs = 0; rd = 0; wr = 0; addr = 0; d_in = 0; ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_en", enable_esp, 0);
    reset = 1;
    rd_reg(A_THRESH, v); chk("rst_thresh", v, 8);
    // single channel grant with duration 3
    wr_reg(A_TURB, 32'h0205);
    wr_reg(A_DUR, 3);
    wr_reg(A_REQ, 4);
    wr_reg(A_CTRL, 1);
    wait_en(1);
    chk("t1_en_rise", enable_esp, 1);
    chk("t1_led_before", led, 0);
    wait_led(1);
    chk("t1_led", led, 4);
    len = 0;
    while (led === 4'h4 && len < 50) begin
      chk("t1_en_with_led", enable_esp, 1);
      len++;
      @(negedge clk);
    end
    chk("t1_len", len, 3);
    repeat (3) @(negedge clk);
    rd_reg(A_REQ, v); chk("t1_req", v, 0);
    rd_reg(A_STAT, v); chk("t1_state", v[2:0], 1);
    // round robin from rr pointer 0 after reset
    reset = 0;
    @(negedge clk);
    reset = 1;
    wr_reg(A_REQ, 32'hF);
    wr_reg(A_CTRL, 1);
    for (int k = 0; k < 4; k++) begin
      wait_led(1);
      chk($sformatf("t2_grant%0d", k), led, 32'(1 << k));
      wait_led(0);
    end
    wr_reg(A_REQ, 1);
    wait_led(1);
    chk("t2_wrap", led, 1);
    wait_led(0);
    // blocked by turbidity, then released
    wr_reg(A_TURB, 32'h010C);
    wr_reg(A_REQ, 2);
    repeat (5) @(negedge clk);
    chk("t3_no_valve", led, 0);
    rd_reg(A_STAT, v);
    chk("t3_blocked", v[31:24], 8'h02);
    chk("t3_state", v[2:0], 1);
    wr_reg(A_TURB, 32'h0103);
    wait_led(1);
    chk("t3_grant", led, 2);
    wait_led(0);
    repeat (2) @(negedge clk);
    rd_reg(A_STAT, v); chk("t3_unblocked", v[31:24], 0);
    // ready timeout
    wr_reg(A_TOUT, 10);
    ready = 0;
    wr_reg(A_REQ, 1);
    wait_en(1);
    chk("t4_en", enable_esp, 1);
    len = 0;
    while (enable_esp === 1'b1 && len < 50) begin
      len++;
      @(negedge clk);
    end
    chk("t4_en_len", len, 10);
    repeat (2) @(negedge clk);
    rd_reg(A_STAT, v); chk("t4_fault", v[23:16], 8'h01);
    rd_reg(A_REQ, v); chk("t4_req_clr", v, 0);
    ready = 1;
    wr_reg(A_REQ, 1);
    repeat (10) @(negedge clk);
    chk("t4_faulted_led", led, 0);
    chk("t4_faulted_en", enable_esp, 0);
    rd_reg(A_REQ, v); chk("t4_req_held", v, 1);
    wr_reg(A_FCLR, 1);
    wait_led(1);
    chk("t4_after_clr", led, 1);
    wait_led(0);
    rd_reg(A_STAT, v); chk("t4_fault_clr", v[23:16], 0);
    // asynchronous reset mid-OPEN
    wr_reg(A_DUR, 20);
    wr_reg(A_REQ, 4);
    wait_led(1);
    chk("t5_open", led, 4);
    #2 reset = 0;
    #1;
    chk("t5_led_async", led, 0);
    chk("t5_en_async", enable_esp, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    rd_reg(A_CTRL, v); chk("t5_ctrl", v, 0);
    rd_reg(A_THRESH, v); chk("t5_thresh", v, 8);
    rd_reg(A_DUR, v); chk("t5_dur", v, 0);
    rd_reg(A_TOUT, v); chk("t5_tout", v, 1000);
    rd_reg(A_REQ, v); chk("t5_req", v, 0);
    rd_reg(A_STAT, v); chk("t5_status", v, 0);
    rd_reg(A_EN, v); chk("t5_get_en", v, 0);
    rd_reg(A_LED, v); chk("t5_get_led", v, 0);
    // unmapped / deselected reads, out-of-range channel write
    rd_reg(5'h1F, v); chk("t6_unmapped", v, 0);
    @(negedge clk);
    cs = 0; rd = 1; addr = {27'd0, A_THRESH};
    #1 chk("t6_cs0", d_out, 0);
    rd = 0;
    wr_reg(A_TURB, 32'h070F);
    wr_reg(A_REQ, 8);
    repeat (3) @(negedge clk);
    rd_reg(A_STAT, v); chk("t6_ch7_ignored", v[31:24], 0);
    rd_reg(A_THRESH, v); chk("t6_thresh_kept", v, 8);
    wr_reg(A_TURB, 32'h030F);
    repeat (3) @(negedge clk);
    rd_reg(A_STAT, v); chk("t6_ch3_blocked", v[31:24], 8'h08);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
